// File: rtl/mem_io_bridge.sv
// CPU memory-port bridge: runs each CPU strobe cycle against asynchronous SRAM
// with programmable wait states, or against a single memory-mapped I/O word.
module mem_io_bridge #(
    parameter int          WAIT_STATES = 2,
    parameter logic [19:0] IO_ADDR     = 20'h0FFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cpu_ce_n,
    input  logic        cpu_oe_n,
    input  logic        cpu_we_n,
    input  logic        cpu_ub_n,
    input  logic        cpu_lb_n,
    input  logic [19:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        mem_ready,
    input  logic [15:0] switches,
    output logic [15:0] hex_out,
    output logic [19:0] sram_addr,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n,
    input  logic [15:0] sram_dq_in,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    output logic        access_err
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        ub_q, ub_d, lb_q, lb_d, wr_q, wr_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] hex_q, hex_d;
    logic        err_q, err_d;

    logic req, illegal, released, active;

    assign req      = !cpu_ce_n && (cpu_oe_n ^ cpu_we_n);
    assign illegal  = !cpu_ce_n && !cpu_oe_n && !cpu_we_n;
    assign released = cpu_ce_n || (cpu_oe_n && cpu_we_n);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ub_q    <= 1'b1;
            lb_q    <= 1'b1;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            hex_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ub_q    <= ub_d;
            lb_q    <= lb_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            hex_q   <= hex_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ub_d    = ub_q;
        lb_d    = lb_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        hex_d   = hex_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (illegal) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else if (req) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    ub_d    = cpu_ub_n;
                    lb_d    = cpu_lb_n;
                    wr_d    = !cpu_we_n;
                    if (cpu_addr == IO_ADDR) begin
                        // I/O side effects land on the acceptance edge so they are visible in DONE
                        if (!cpu_we_n) begin
                            if (!cpu_ub_n) hex_d[15:8] = cpu_wdata[15:8];
                            if (!cpu_lb_n) hex_d[7:0]  = cpu_wdata[7:0];
                        end else begin
                            rdata_d = switches;
                        end
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                cnt_d   = WS;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!wr_q) rdata_d = sram_dq_in;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:    state_d = S_RELEASE;
            S_RELEASE: if (released) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Strobes decode straight from the registered state so reset deasserts them asynchronously
    assign active      = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign sram_addr   = active ? addr_q : '0;
    assign sram_ce_n   = !active;
    assign sram_ub_n   = active ? ub_q : 1'b1;
    assign sram_lb_n   = active ? lb_q : 1'b1;
    assign sram_oe_n   = !((state_q == S_ACCESS) && !wr_q);
    assign sram_we_n   = !((state_q == S_ACCESS) && wr_q);
    assign sram_dq_oe  = active && wr_q;
    assign sram_dq_out = (active && wr_q) ? wdata_q : '0;
    assign mem_ready   = (state_q == S_DONE);
    assign cpu_rdata   = rdata_q;
    assign hex_out     = hex_q;
    assign access_err  = err_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: a default and a zero-wait-state build
// run the same CPU traffic against behavioural SRAMs and a word-level model.
module tb_mem_io_bridge;

    localparam int          WS = 2;
    localparam logic [19:0] IO = 20'h0FFFF;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    logic        cpu_ce_n = 1'b1, cpu_oe_n = 1'b1, cpu_we_n = 1'b1;
    logic        cpu_ub_n = 1'b1, cpu_lb_n = 1'b1;
    logic [19:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0, switches = '0;

    // index 0: WAIT_STATES=0 build, index 1: WAIT_STATES=WS build
    logic [15:0] rdata[2], hex[2], sdq_out[2], sdq_in[2];
    logic [19:0] saddr[2];
    logic        mr[2], ce[2], oe[2], we[2], ub[2], lb[2], dqoe[2], err[2];

    mem_io_bridge #(.WAIT_STATES(0), .IO_ADDR(IO)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .cpu_ce_n(cpu_ce_n), .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n),
        .cpu_ub_n(cpu_ub_n), .cpu_lb_n(cpu_lb_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(rdata[0]), .mem_ready(mr[0]), .switches(switches), .hex_out(hex[0]),
        .sram_addr(saddr[0]), .sram_ce_n(ce[0]), .sram_oe_n(oe[0]), .sram_we_n(we[0]),
        .sram_ub_n(ub[0]), .sram_lb_n(lb[0]), .sram_dq_in(sdq_in[0]), .sram_dq_out(sdq_out[0]),
        .sram_dq_oe(dqoe[0]), .access_err(err[0]));

    mem_io_bridge #(.WAIT_STATES(WS), .IO_ADDR(IO)) u_dut2 (
        .Clk(Clk), .Reset(Reset), .cpu_ce_n(cpu_ce_n), .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n),
        .cpu_ub_n(cpu_ub_n), .cpu_lb_n(cpu_lb_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(rdata[1]), .mem_ready(mr[1]), .switches(switches), .hex_out(hex[1]),
        .sram_addr(saddr[1]), .sram_ce_n(ce[1]), .sram_oe_n(oe[1]), .sram_we_n(we[1]),
        .sram_ub_n(ub[1]), .sram_lb_n(lb[1]), .sram_dq_in(sdq_in[1]), .sram_dq_out(sdq_out[1]),
        .sram_dq_oe(dqoe[1]), .access_err(err[1]));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] init_word(input logic [19:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic ubn, input logic lbn);
        return {ubn ? old[15:8] : nw[15:8], lbn ? old[7:0] : nw[7:0]};
    endfunction

    // external asynchronous SRAMs, one per build
    logic [15:0] smem0 [logic [19:0]];
    logic [15:0] smem1 [logic [19:0]];
    always @(posedge Clk) begin
        if (!ce[0] && !we[0])
            smem0[saddr[0]] = merge(smem0.exists(saddr[0]) ? smem0[saddr[0]] : init_word(saddr[0]),
                                    sdq_out[0], ub[0], lb[0]);
        if (!ce[1] && !we[1])
            smem1[saddr[1]] = merge(smem1.exists(saddr[1]) ? smem1[saddr[1]] : init_word(saddr[1]),
                                    sdq_out[1], ub[1], lb[1]);
    end
    always @(negedge Clk) begin
        sdq_in[0] = smem0.exists(saddr[0]) ? smem0[saddr[0]] : init_word(saddr[0]);
        sdq_in[1] = smem1.exists(saddr[1]) ? smem1[saddr[1]] : init_word(saddr[1]);
    end

    // reference model: word memory plus the two architectural registers
    logic [15:0] ref_mem [logic [19:0]];
    logic [15:0] exp_rdata = '0, exp_hex = '0;

    function automatic logic [15:0] ref_lookup(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    typedef struct {
        int          cyc;
        logic [15:0] rd;
        logic [15:0] hx;
        int          nwe;
        int          noe;
        int          ndq;
    } item_t;
    item_t q0[$];
    item_t q1[$];

    int cwe[2], coe[2], cdq[2], rc[2];

    always @(negedge Clk) begin
        if (!Reset) begin
            for (int d = 0; d < 2; d++) begin
                cwe[d] = 0; coe[d] = 0; cdq[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                item_t it;
                int    n;
                if (!oe[d]) chk($sformatf("d%0d dq_oe_during_read", d), 32'(dqoe[d]), 32'd0);
                if (!we[d]) cwe[d]++;
                if (!oe[d]) coe[d]++;
                if (dqoe[d]) cdq[d]++;
                if (mr[d]) begin
                    rc[d]++;
                    n = (d == 0) ? q0.size() : q1.size();
                    chk($sformatf("d%0d ready_expected", d), 32'(n > 0), 32'd1);
                    if (n > 0) begin
                        it = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("d%0d ready_cycle", d), 32'(cyc), 32'(it.cyc));
                        chk($sformatf("d%0d cpu_rdata", d), 32'(rdata[d]), 32'(it.rd));
                        chk($sformatf("d%0d hex_out", d), 32'(hex[d]), 32'(it.hx));
                        chk($sformatf("d%0d we_low_cycles", d), 32'(cwe[d]), 32'(it.nwe));
                        chk($sformatf("d%0d oe_low_cycles", d), 32'(coe[d]), 32'(it.noe));
                        chk($sformatf("d%0d dq_oe_cycles", d), 32'(cdq[d]), 32'(it.ndq));
                    end
                    cwe[d] = 0; coe[d] = 0; cdq[d] = 0;
                end
            end
        end
    end

    // Issue one CPU access at a negedge with both builds idle; hold strobes until the
    // slower build completes (plus 'hold' extra cycles), then release and let both return to IDLE.
    task automatic do_access(input bit wr, input logic [19:0] a, input logic [15:0] wd,
                             input logic ubn, input logic lbn, input logic [15:0] sw, input int hold);
        item_t it;
        bit    io, got;
        io = (a == IO);
        switches = sw; cpu_addr = a; cpu_wdata = wd; cpu_ub_n = ubn; cpu_lb_n = lbn;
        cpu_ce_n = 1'b0; cpu_oe_n = wr; cpu_we_n = ~wr;
        if (wr) begin
            if (io) exp_hex = merge(exp_hex, wd, ubn, lbn);
            else    ref_mem[a] = merge(ref_lookup(a), wd, ubn, lbn);
        end else begin
            exp_rdata = io ? sw : ref_lookup(a);
        end
        it.rd = exp_rdata; it.hx = exp_hex;
        it.cyc = cyc + (io ? 1 : 3);
        it.nwe = (!io && wr) ? 1 : 0; it.noe = (!io && !wr) ? 1 : 0; it.ndq = (!io && wr) ? 2 : 0;
        q0.push_back(it);
        it.cyc = cyc + (io ? 1 : 3 + WS);
        it.nwe = (!io && wr) ? WS + 1 : 0; it.noe = (!io && !wr) ? WS + 1 : 0;
        it.ndq = (!io && wr) ? WS + 2 : 0;
        q1.push_back(it);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge Clk);
            got = mr[1];
        end
        chk("access_timeout", 32'(got), 32'd1);
        repeat (hold) @(negedge Clk);
        cpu_ce_n = 1'b1; cpu_oe_n = 1'b1; cpu_we_n = 1'b1;
        repeat (2 + $urandom_range(0, 2)) @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [19:0] pool [7];
    initial begin
        int  base0, base1;
        bit  got;
        pool[0] = 20'h00010; pool[1] = 20'h00200; pool[2] = 20'h0ABCD; pool[3] = 20'hF0000;
        pool[4] = IO;        pool[5] = 20'h0FFFE; pool[6] = 20'h1FFFF;

        repeat (3) @(negedge Clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst sram strobes", 32'({ce[d], oe[d], we[d], ub[d], lb[d]}), 32'h1F);
            chk("rst dq_oe/ready/err", 32'({dqoe[d], mr[d], err[d]}), 32'd0);
            chk("rst sram_addr", 32'(saddr[d]), 32'd0);
            chk("rst dq_out", 32'(sdq_out[d]), 32'd0);
            chk("rst cpu_rdata", 32'(rdata[d]), 32'd0);
            chk("rst hex_out", 32'(hex[d]), 32'd0);
        end
        Reset = 1'b1;
        repeat (2) @(negedge Clk);

        do_access(1'b1, 20'h00123, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 0);
        do_access(1'b0, 20'h00123, 16'h0000, 1'b0, 1'b0, 16'h0000, 0);
        chk("sram readback", 32'(rdata[1]), 32'hBEEF);

        do_access(1'b0, IO, 16'h0000, 1'b0, 1'b0, 16'h00A5, 0);
        chk("io read", 32'(rdata[1]), 32'h00A5);
        do_access(1'b1, IO, 16'h1234, 1'b1, 1'b0, 16'h0000, 0);
        chk("io write lb only", 32'(hex[1]), 32'h0034);

        base0 = rc[0]; base1 = rc[1];
        do_access(1'b0, 20'h00123, 16'h0000, 1'b0, 1'b0, 16'h0000, 20);
        chk("held strobe pulses d0", 32'(rc[0] - base0), 32'd1);
        chk("held strobe pulses d2", 32'(rc[1] - base1), 32'd1);
        do_access(1'b0, 20'h00123, 16'h0000, 1'b0, 1'b0, 16'h0000, 0);

        cpu_ce_n = 1'b0; cpu_oe_n = 1'b0; cpu_we_n = 1'b0; cpu_addr = 20'h00200;
        repeat (5) @(negedge Clk);
        chk("illegal sets err d0", 32'(err[0]), 32'd1);
        chk("illegal sets err d2", 32'(err[1]), 32'd1);
        cpu_ce_n = 1'b1; cpu_oe_n = 1'b1; cpu_we_n = 1'b1;
        repeat (3) @(negedge Clk);
        do_access(1'b0, 20'h00200, 16'h0000, 1'b0, 1'b0, 16'h0000, 0);
        chk("err sticky", 32'({err[0], err[1]}), 32'h3);

        for (int i = 0; i < 40; i++)
            do_access(1'($urandom_range(0, 1)), pool[$urandom_range(0, 6)], 16'($urandom),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 0);

        do_access(1'b1, IO, 16'hCAFE, 1'b0, 1'b0, 16'h0000, 0);
        cpu_addr = 20'h7FFFF; cpu_wdata = 16'h5555; cpu_ub_n = 1'b0; cpu_lb_n = 1'b0;
        cpu_ce_n = 1'b0; cpu_oe_n = 1'b1; cpu_we_n = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge Clk);
            got = !we[1];
        end
        chk("reach access before reset", 32'(got), 32'd1);
        #2 Reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async rst we_n/ce_n", 32'({we[d], ce[d]}), 32'h3);
            chk("async rst dq_oe/ready", 32'({dqoe[d], mr[d]}), 32'd0);
            chk("async rst hex_out", 32'(hex[d]), 32'd0);
        end
        q0.delete(); q1.delete();
        exp_rdata = '0; exp_hex = '0;
        cpu_ce_n = 1'b1; cpu_we_n = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        base0 = rc[0]; base1 = rc[1];
        repeat (10) @(negedge Clk);
        chk("no ready after reset", 32'((rc[0] - base0) + (rc[1] - base1)), 32'd0);
        chk("err cleared by reset", 32'({err[0], err[1]}), 32'd0);
        do_access(1'b0, 20'h00123, 16'h0000, 1'b0, 1'b0, 16'h0000, 0);

        repeat (5) @(negedge Clk);
        chk("scoreboard drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sits directly downstream of the CPU core's memory port; consumes its active-low strobes (CE/OE/WE/UB/LB), 20-bit address and write data.
- Runs each access against external asynchronous SRAM with a programmable number of wait states, or against the memory-mapped I/O location (switches on read, hex display latch on write).
- Returns read data and a one-cycle mem_ready pulse to the CPU.

Parameters:
- WAIT_STATES, 2, extra strobe cycles per SRAM access (legal range 0..15)
- IO_ADDR, 20'h0FFFF, address decoded as I/O; never forwarded to SRAM

Ports:
- Clk  in  1  system clock; all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- cpu_ce_n  in  1  CPU chip enable, active low
- cpu_oe_n  in  1  CPU read strobe, active low
- cpu_we_n  in  1  CPU write strobe, active low
- cpu_ub_n  in  1  upper byte enable, active low
- cpu_lb_n  in  1  lower byte enable, active low
- cpu_addr  in  20  access address
- cpu_wdata  in  16  write data from CPU
- cpu_rdata  out  16  registered read data to CPU
- mem_ready  out  1  one-cycle completion pulse
- switches  in  16  board switches, returned on I/O read
- hex_out  out  16  I/O write latch driving hex display
- sram_addr  out  20  SRAM address
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active low
- sram_dq_in  in  16  SRAM data in
- sram_dq_out  out  16  SRAM write data
- sram_dq_oe  out  1  tristate enable for sram_dq_out (1 = drive bus)
- access_err  out  1  sticky error flag

Behaviour:
- Reset (Reset=0, asynchronous):
  - Outputs: all sram_*_n = 1, sram_dq_oe = 0, sram_addr = 0, sram_dq_out = 0, cpu_rdata = 0, hex_out = 0, mem_ready = 0, access_err = 0.
  - State returns to IDLE and the wait counter clears.
  - Reset asserted mid-access aborts the access immediately; no mem_ready is produced.
- Request definition: cpu_ce_n=0 AND exactly one of cpu_oe_n / cpu_we_n low, sampled in IDLE.
- Acceptance (request sampled in IDLE): latch addr, wdata, ub_n, lb_n and direction into internal registers. CPU inputs are not used again for this access.
- Illegal request: ce_n=0 with both oe_n and we_n low, sampled in IDLE. Sets access_err (cleared only by reset). No access is performed; state goes to RELEASE; no mem_ready.
- States:
  - IDLE: no strobes driven. On request: to SETUP if addr != IO_ADDR, else to DONE (I/O path).
  - SETUP (1 cycle): sram_addr, sram_ce_n=0 and byte enables driven from latched values. On a write, sram_dq_out = latched wdata and sram_dq_oe = 1. oe_n/we_n stay high.
  - ACCESS (WAIT_STATES+1 cycles; counter loaded with WAIT_STATES, decrements to 0): sram_oe_n=0 (read) or sram_we_n=0 (write). On the final ACCESS cycle edge, reads capture sram_dq_in into cpu_rdata.
  - DONE (1 cycle): mem_ready=1; all SRAM strobes high; sram_dq_oe=0.
    - I/O read: cpu_rdata <= switches, captured on entry.
    - I/O write: hex_out[15:8] updated iff ub_n latched low; hex_out[7:0] updated iff lb_n latched low.
  - RELEASE: waits until cpu_ce_n=1 OR (cpu_oe_n=1 AND cpu_we_n=1), then goes to IDLE. This prevents a held strobe from retriggering.
- Latency, request sampled at edge N:
  - SRAM access: mem_ready high during cycle N+3+WAIT_STATES (N+5 at default).
  - I/O access: mem_ready high during cycle N+1.
- Back-to-back accesses: minimum spacing is DONE → RELEASE → IDLE, i.e. the next request is accepted no earlier than 2 cycles after mem_ready.
- cpu_rdata holds its value until the next read completes; writes never modify it.
- Strobe changes during SETUP/ACCESS/DONE are ignored.
- sram_dq_oe is never high while sram_oe_n=0.

Test Plan:
- SRAM write then read, WAIT_STATES=2: write addr 20'h00123 data 16'hBEEF, ub_n=lb_n=0 → sram_we_n low exactly 3 cycles, sram_dq_oe high during SETUP+ACCESS, mem_ready at N+5. Read same address with model returning 16'hBEEF → cpu_rdata=16'hBEEF, mem_ready at N+5, sram_dq_oe=0 throughout.
- I/O path: switches=16'h00A5, read IO_ADDR → mem_ready at N+1, cpu_rdata=16'h00A5, SRAM strobes stay high. Write 16'h1234 with ub_n=1, lb_n=0 → hex_out=16'h0034.
- Held strobe: keep cpu_ce_n=0, cpu_oe_n=0 for 20 cycles → exactly one mem_ready pulse. Deassert, reassert → second access starts.
- Illegal request: ce_n=0, oe_n=0, we_n=0 → access_err=1, no SRAM strobe, no mem_ready. Following legal read completes normally and access_err stays 1.
- Reset mid-access: assert Reset low during ACCESS of a write → sram_we_n=1 and sram_dq_oe=0 same cycle (asynchronous), hex_out=0, no mem_ready after release.
- WAIT_STATES=0 build: read → sram_oe_n low 1 cycle, mem_ready at N+3.
